// File: rtl/bcd_digit_accumulator_pkg.sv
// Shared types and constants for the digit-serial BCD accumulator.
// Optional feature macro: BCD_ACC_OVF_EN (drop digits past NDIGITS and flag error).
package bcd_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEC_BASE    = 10;
    localparam int DEF_NDIGITS = 4;
    localparam int DEF_OUT_W   = 14;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_accumulator_if.sv
// Digit-in / result-out handshake bundle between a digit source and the accumulator.
// master = digit producer and result consumer; slave = the accumulator.
interface bcd_digit_accumulator_if
    import bcd_acc_pkg::*;
#(
    parameter int NDIGITS = DEF_NDIGITS,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int CNT_W   = cnt_w(NDIGITS)
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_bin;
    logic             in_invalid;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_value;
    logic             out_err;
    logic [CNT_W-1:0] out_ndig;

    modport master (
        output in_valid, in_bin, in_invalid, in_last, out_ready,
        input  in_ready, out_valid, out_value, out_err, out_ndig
    );

    modport slave (
        input  in_valid, in_bin, in_invalid, in_last, out_ready,
        output in_ready, out_valid, out_value, out_err, out_ndig
    );

endinterface

// File: rtl/bcd_digit_accumulator_mul10_add.sv
// Combinational acc*10 + digit using two shifts and adds, truncated to OUT_W.
module mul10_add
    import bcd_acc_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [OUT_W-1:0] result
);
    logic [OUT_W-1:0] digit_ext;

    assign digit_ext = {{(OUT_W-4){1'b0}}, digit};
    assign result    = (acc << 3) + (acc << 1) + digit_ext;

endmodule

// File: rtl/bcd_digit_accumulator.sv
// Folds an MSD-first stream of converted BCD digits into a binary value (acc*10+d).
// Define BCD_ACC_OVF_EN to drop digits beyond NDIGITS and flag them as errors.
module bcd_digit_accumulator
    import bcd_acc_pkg::*;
#(
    parameter int NDIGITS = DEF_NDIGITS,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_digit_accumulator_if.slave  bus
);
    localparam int CNT_W = cnt_w(NDIGITS);

    // Largest NDIGITS-digit decimal value must fit the result register.
    if ((DEC_BASE ** NDIGITS) - 1 >= (2 ** OUT_W)) begin : g_bad_cfg
        $error("OUT_W too narrow for NDIGITS");
    end

    state_e           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d, acc_next;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_ready_w;
    logic             accept;
    logic             out_fire;
    logic             good;
    logic             full;
    logic [3:0]       digit;

    // in_ready depends only on state (and reset), never on in_valid.
    assign in_ready_w = rst_n && (state_q != HOLD);
    assign accept     = bus.in_valid && in_ready_w;
    assign out_fire   = (state_q == HOLD) && bus.out_ready;

    assign good  = !bus.in_invalid && (bus.in_bin < 8'(DEC_BASE));
    assign digit = good ? bus.in_bin[3:0] : 4'd0;
    assign full  = (cnt_q == CNT_W'(NDIGITS));

    mul10_add #(.OUT_W(OUT_W)) u_mul10_add (
        .acc    (acc_q),
        .digit  (digit),
        .result (acc_next)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (accept) begin
`ifdef BCD_ACC_OVF_EN
            if (full) begin
                err_d = 1'b1;
            end else begin
                acc_d = acc_next;
                if (!good) err_d = 1'b1;
            end
`else
            acc_d = acc_next;
            if (!good) err_d = 1'b1;
`endif
            if (!full) cnt_d = cnt_q + 1'b1;
            state_d = bus.in_last ? HOLD : ACC;
        end else if (out_fire) begin
            state_d = IDLE;
            acc_d   = '0;
            err_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result outputs come straight from flops; in HOLD nothing changes them.
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_value = acc_q;
    assign bus.out_err   = err_q;
    assign bus.out_ndig  = cnt_q;

endmodule
